// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Multi-cycle ripple adder/subtractor. A WIDTH-bit operation is split into
//   N = WIDTH/CHUNK chunks that are added one per clock, LSB chunk first. The
//   carry between chunks is kept in a register, so the combinational path is
//   only one CHUNK-bit adder wide.
//
//   Handshake: START is accepted on an edge where BUSY=0. The operands are
//   latched, BUSY rises, and DONE pulses for one cycle N edges later, when S,
//   CO and OVF have just been updated. START is ignored while BUSY=1.
//   Subtraction is A + ~B + ~CI, so in subtract mode CO=1 means "no borrow".
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   synchronous active-low reset
//   START      in   operation request
//   A, B       in   operands (WIDTH)
//   CI         in   carry-in (add) / borrow-in (sub)
//   SUB        in   0: A+B+CI, 1: A-B-CI
//   BUSY       out  high while an operation is in progress (RUN/FIN)
//   DONE       out  one-cycle pulse, the result registers were just loaded
//   S          out  result (WIDTH)
//   CO         out  carry out of the MSB
//   OVF        out  signed overflow
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 FIN)
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OVF,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted in subtract mode
    logic [WIDTH-1:0] acc;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   sum_ext;
    logic             c_msb;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // One chunk of the ripple: chunk k of both operands plus the carry register.
    always_comb begin
        a_c      = a_r[k*CHUNK +: CHUNK];
        b_c      = b_r[k*CHUNK +: CHUNK];
        sum_ext  = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
        // Carry into the top bit of this chunk, recovered from the sum bit:
        // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. Works for CHUNK=1 as well.
        c_msb    = sum_ext[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
        acc_next = acc;
        acc_next[k*CHUNK +: CHUNK] = sum_ext[CHUNK-1:0];
        last     = (k == KW'(N - 1));
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            S     <= '0;
            CO    <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        a_r   <= A;
                        b_r   <= SUB ? ~B : B;
                        carry <= SUB ? ~CI : CI;
                        k     <= '0;
                        acc   <= '0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= sum_ext[CHUNK];
                    if (last) begin
                        // Result registers load on the edge that enters FIN.
                        S     <= acc_next;
                        CO    <= sum_ext[CHUNK];
                        OVF   <= c_msb ^ sum_ext[CHUNK];
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
